// File: rtl/dmi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_pkg
//  Purpose  : Shared types and constants for the DMI request arbiter:
//             aux issue FSM states, read-data owner encoding, default DM
//             address width and the out-of-range address mask.
//  Revision : 1.0  initial release
// ============================================================================
package dmi_pkg;

  // Default debug-module register address width
  localparam int DM_AW_DEFAULT = 7;

  // Aux issue FSM: idle/ready to issue, access in flight, response held
  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_INFL = 2'd1,
    A_HOLD = 2'd2
  } a_state_e;

  // Which requester owns the DM read data returned in the next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_J    = 2'd1,
    OWN_A    = 2'd2
  } owner_e;

  // Mask selecting JTAG address bits that must be zero for a DM hit
  function automatic logic [31:0] oor_mask(input int aw);
    return ~((32'd1 << aw) - 32'd1);
  endfunction

  localparam logic [31:0] OOR_MASK_DEFAULT = oor_mask(DM_AW_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/dmi_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_req_arbiter_if
//  Purpose  : Bundle of JTAG, aux-master, debug-module and counter signals
//             around the DMI request arbiter. 'slave' is the arbiter view,
//             'master' is the view of the surrounding environment.
//  Revision : 1.0  initial release
// ============================================================================
interface dmi_req_arbiter_if
  import dmi_pkg::*;
#(
  parameter int DM_AW = DM_AW_DEFAULT
) ();

  // JTAG path (from TCK-to-core synchroniser)
  logic             j_reg_en;
  logic             j_reg_wr_en;
  logic [31:0]      j_wr_addr;
  logic [31:0]      j_wr_data;
  logic             j_rd_ack;
  logic [31:0]      j_rd_data;

  // Aux master request/response
  logic             a_req_valid;
  logic             a_req_ready;
  logic             a_req_wr;
  logic [DM_AW-1:0] a_req_addr;
  logic [31:0]      a_req_wdata;
  logic             a_rsp_valid;
  logic             a_rsp_ready;
  logic [31:0]      a_rsp_rdata;

  // Debug-module register port
  logic             dm_reg_en;
  logic             dm_reg_wr_en;
  logic [DM_AW-1:0] dm_reg_addr;
  logic [31:0]      dm_reg_wdata;
  logic [31:0]      dm_reg_rdata;

  // Deferral statistics
  logic             cnt_clr;
  logic [15:0]      defer_cnt;

  modport slave (
    input  j_reg_en, j_reg_wr_en, j_wr_addr, j_wr_data,
    output j_rd_ack, j_rd_data,
    input  a_req_valid, a_req_wr, a_req_addr, a_req_wdata,
    output a_req_ready,
    output a_rsp_valid, a_rsp_rdata,
    input  a_rsp_ready,
    output dm_reg_en, dm_reg_wr_en, dm_reg_addr, dm_reg_wdata,
    input  dm_reg_rdata,
    input  cnt_clr,
    output defer_cnt
  );

  modport master (
    output j_reg_en, j_reg_wr_en, j_wr_addr, j_wr_data,
    input  j_rd_ack, j_rd_data,
    output a_req_valid, a_req_wr, a_req_addr, a_req_wdata,
    input  a_req_ready,
    input  a_rsp_valid, a_rsp_rdata,
    output a_rsp_ready,
    input  dm_reg_en, dm_reg_wr_en, dm_reg_addr, dm_reg_wdata,
    output dm_reg_rdata,
    output cnt_clr,
    input  defer_cnt
  );

endinterface
`default_nettype wire

// File: rtl/dmi_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_req_fifo
//  Purpose  : Small synchronous FIFO holding queued aux requests. Pointers
//             carry one extra wrap bit so full and empty are distinguishable
//             without a separate counter. Head entry is presented
//             combinationally on rdata_o.
//  Revision : 1.0  initial release
// ============================================================================
module dmi_req_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;

  // Full when indices match but wrap bits differ; empty when both match
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer advance; callers never push when full nor pop when empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared by reset so queued entries are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset as validity comes from pointers
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/dmi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmi_req_arbiter
//  Purpose  : Shares the debug-module register port between the JTAG DMI
//             path (absolute priority, fixed one-cycle ack) and a queued
//             aux master (valid/ready, one access outstanding). A registered
//             owner flag steers the next-cycle DM read data to its requester.
//  Revision : 1.0  initial release
// ============================================================================
module dmi_req_arbiter
  import dmi_pkg::*;
#(
  parameter int AUX_DEPTH = 2,
  parameter int DM_AW     = DM_AW_DEFAULT
) (
  input  wire logic        core_clk,
  input  wire logic        core_rst_n,
  dmi_req_arbiter_if.slave bus
);

  localparam int          EW         = 1 + DM_AW + 32;
  localparam logic [31:0] RANGE_MASK = oor_mask(DM_AW);

  // FIFO interface
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;
  logic             head_wr;
  logic [DM_AW-1:0] head_addr;
  logic [31:0]      head_wdata;

  // Arbitration and FSM
  logic             j_hit;
  logic             issue_ok;
  logic             aux_issue;
  logic             defer_hit;
  a_state_e         state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             aux_wr_q, aux_wr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             j_ack_q;
  logic [15:0]      defer_q, defer_d;

  // ---------------------------------------------------------------------------
  // Aux request queue
  // ---------------------------------------------------------------------------
  assign fifo_push       = bus.a_req_valid && !fifo_full;
  assign fifo_pop        = aux_issue;
  assign fifo_wdata      = {bus.a_req_wr, bus.a_req_addr, bus.a_req_wdata};
  assign bus.a_req_ready = !fifo_full;

  assign head_wr    = fifo_rdata[EW-1];
  assign head_addr  = fifo_rdata[DM_AW+31:32];
  assign head_wdata = fifo_rdata[31:0];

  dmi_req_fifo #(
    .WIDTH (EW),
    .DEPTH (AUX_DEPTH)
  ) u_fifo (
    .clk     (core_clk),
    .rst_n   (core_rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A J pulse blocks aux issue even when its address misses the DM, which
  // keeps the rule simple and matches how deferrals are counted.
  assign j_hit    = bus.j_reg_en && ((bus.j_wr_addr & RANGE_MASK) == 32'd0);
  assign issue_ok = !fifo_empty && !bus.j_reg_en &&
                    (!rsp_valid_q || bus.a_rsp_ready);

  // Aux issue FSM next state, response register and deferral detection
  always_comb begin
    state_d     = state_q;
    aux_issue   = 1'b0;
    defer_hit   = 1'b0;
    aux_wr_d    = aux_wr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      A_IDLE: begin
        if (issue_ok) begin
          aux_issue = 1'b1;
          state_d   = A_INFL;
        end else if (!fifo_empty && bus.j_reg_en &&
                     (!rsp_valid_q || bus.a_rsp_ready)) begin
          defer_hit = 1'b1;
        end
      end
      A_INFL: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (owner_q == OWN_A && !aux_wr_q) ? bus.dm_reg_rdata : 32'd0;
        state_d     = A_HOLD;
      end
      A_HOLD: begin
        if (bus.a_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (issue_ok) begin
            aux_issue = 1'b1;
            state_d   = A_INFL;
          end else begin
            state_d = A_IDLE;
          end
        end
      end
      default: state_d = A_IDLE;
    endcase
    if (aux_issue) aux_wr_d = head_wr;
  end

  // Owner of the read data the DM returns in the following cycle
  always_comb begin
    owner_d = OWN_NONE;
    if (j_hit && !bus.j_reg_wr_en) owner_d = OWN_J;
    else if (aux_issue)            owner_d = OWN_A;
  end

  // Saturating deferral counter; clear wins over increment
  always_comb begin
    defer_d = defer_q;
    if (bus.cnt_clr)                         defer_d = 16'd0;
    else if (defer_hit && defer_q != 16'hFFFF) defer_d = defer_q + 16'd1;
  end

  // State, owner, response and counter registers
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= A_IDLE;
      owner_q     <= OWN_NONE;
      aux_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      j_ack_q     <= 1'b0;
      defer_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      aux_wr_q    <= aux_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      j_ack_q     <= bus.j_reg_en;
      defer_q     <= defer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // DM port: J in-range access wins, else the aux head on issue, else idle
  // ---------------------------------------------------------------------------
  // DM port drive for the current cycle
  always_comb begin
    bus.dm_reg_en    = 1'b0;
    bus.dm_reg_wr_en = 1'b0;
    bus.dm_reg_addr  = '0;
    bus.dm_reg_wdata = 32'd0;
    if (j_hit) begin
      bus.dm_reg_en    = 1'b1;
      bus.dm_reg_wr_en = bus.j_reg_wr_en;
      bus.dm_reg_addr  = bus.j_wr_addr[DM_AW-1:0];
      bus.dm_reg_wdata = bus.j_wr_data;
    end else if (aux_issue) begin
      bus.dm_reg_en    = 1'b1;
      bus.dm_reg_wr_en = head_wr;
      bus.dm_reg_addr  = head_addr;
      bus.dm_reg_wdata = head_wdata;
    end
  end

  // Return paths: J data is steered straight from the DM during its ack cycle
  assign bus.j_rd_ack    = j_ack_q;
  assign bus.j_rd_data   = (owner_q == OWN_J) ? bus.dm_reg_rdata : 32'd0;
  assign bus.a_rsp_valid = rsp_valid_q;
  assign bus.a_rsp_rdata = rsp_rdata_q;
  assign bus.defer_cnt   = defer_q;

endmodule
`default_nettype wire
